vpu_sram_rd_arbiter: RTL and testbench
======================================

# vpu_sram_rd_arbiter

Shares the banked operand SRAM read ports among the VPU source-port controllers. Each requester issues single-beat or locked multi-beat reads addressed by bank id and row address; the block arbitrates per bank with round-robin priority, drives the bank read strobes, and routes fixed-latency read data back to the granted requester. It sits between the source-port controllers and the SRAM bank macros.

## Interface
- REQ_CNT, 3, number of requesters (source operand ports)
- BANK_CNT, 4, number of SRAM banks; power of two, ≥2
- BANK_DEPTH_LG2, 10, row-address width
- DATA_WIDTH, 256, read data width
- RD_LATENCY, 1, bank cycles from strobe to bank_rdata_i valid (≥1)
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-high
- req_i  in  REQ_CNT  request per requester
- rid_i  in  REQ_CNT×log2(BANK_CNT)  target bank per requester
- addr_i  in  REQ_CNT×BANK_DEPTH_LG2  row address per requester
- reb_i  in  REQ_CNT  read enable, active-low; a request counts only when req_i=1 and reb_i=0
- rlast_i  in  REQ_CNT  1 = last beat, releases bank lock
- ack_o  out  REQ_CNT  grant, combinational, same cycle as the counted request
- rvalid_o  out  REQ_CNT  read data valid, one-cycle pulse
- rdata_o  out  REQ_CNT×DATA_WIDTH  read data per requester
- bank_ceb_o  out  BANK_CNT  bank read strobe, active-low
- bank_addr_o  out  BANK_CNT×BANK_DEPTH_LG2  bank row address
- bank_rdata_i  in  BANK_CNT×DATA_WIDTH  bank read data

## Operation
- Per bank b, candidates are requesters with a counted request and rid_i==b. At most one is acked per bank per cycle. Each requester targets exactly one bank, so it receives at most one ack per cycle.
- Round-robin: each bank keeps pointer ptr[b]. Priority scans from ptr[b] upward and wraps. After a grant to requester r, ptr[b] = (r+1) mod REQ_CNT. Pointer is unchanged when nothing is granted.
- Lock: a grant with rlast_i=0 locks bank b to requester r. While locked, only r can be acked on b; other requests wait with ack_o=0 and are never dropped. The lock releases on r's next grant on b with rlast_i=1. The pointer does not advance while locked; it advances at the releasing grant.
- An uncounted request (reb_i=1) on a locked bank from its owner holds the lock without a strobe.
- Return path: per bank, a RD_LATENCY+1 deep shift register of {valid, requester id}. The id travelling with the data selects which rvalid_o/rdata_o it drives.
- Reset (asserted at any time, including mid-burst): in-flight returns dropped; locks cleared; ptr=0. Outputs: ack_o=0, rvalid_o=0, rdata_o=0, bank_ceb_o all 1, bank_addr_o=0.

## Timing
- Cycle T: counted request and ack_o=1, combinational.
- T+1: bank_ceb_o[b]=0 and bank_addr_o[b]=addr, both registered. Strobe is high in every cycle without a grant.
- T+1+RD_LATENCY: bank_rdata_i sampled into the rdata_o register.
- T+2+RD_LATENCY: rvalid_o[r]=1 with rdata_o[r] valid. Total latency is 3 cycles at RD_LATENCY=1.
- Back-to-back grants to the same bank are allowed every cycle. Throughput is one read per bank per cycle.
- rdata_o holds its last value when rvalid_o=0.
- Requesters hold req_i, rid_i, addr_i, rlast_i stable until acked. The block does not register unacked requests.

## Structure
- VPU_PKG: SRAM_BANK_CNT, SRAM_BANK_CNT_LG2, SRAM_BANK_DEPTH_LG2, SRAM_DATA_WIDTH, SRAM_RD_LATENCY, VPU_SRC_PORT_CNT, and the typedef for the return-tag struct {valid, req_id}.
- Sub-module vpu_rr_arbiter: REQ_CNT-wide round-robin with lock input. Instantiate once per bank, inside a generate loop.
- Top level holds: the candidate mask build, the ack OR-reduce per requester, strobe/address registers, and the per-bank return shift registers.

## Test plan
- Single read: r0 reads bank 2, row 0x1A, rlast=1 -> ack_o[0] at T; bank_ceb_o[2]=0 and addr 0x1A at T+1; rvalid_o[0] with bank-2 data at T+3.
- Contention: r0, r1, r2 request bank 0 every cycle -> acks in order r0, r1, r2, r0 (ptr wrap); three returns in matching order.
- Parallel banks: r0→b0, r1→b1, r2→b3 in the same cycle -> all three acked at T; all three rvalid_o at T+3 with correct per-bank data.
- Lock: r1 issues a 3-beat burst to b1 (rlast 0,0,1) while r0 also requests b1 -> r0 not acked for those 3 cycles; r0 acked the cycle after r1's rlast beat.
- reb_i=1 with req_i=1 -> no ack, no strobe, no rvalid.
- Async reset asserted between ack and return -> all outputs go to reset values immediately; no rvalid_o after deassert; the next request is served starting at ptr=0.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared VPU constants and the read-return tag carried alongside bank read data.
// Sizes default the SRAM read arbiter and its return-path shift registers.
package vpu_pkg;
   localparam int SRAM_BANK_CNT       = 4;
   localparam int SRAM_BANK_CNT_LG2   = $clog2(SRAM_BANK_CNT);
   localparam int SRAM_BANK_DEPTH_LG2 = 10;
   localparam int SRAM_DATA_WIDTH     = 256;
   localparam int SRAM_RD_LATENCY     = 1;
   localparam int VPU_SRC_PORT_CNT    = 3;
   localparam int VPU_SRC_PORT_ID_W   = (VPU_SRC_PORT_CNT > 1) ? $clog2(VPU_SRC_PORT_CNT) : 1;

   typedef struct packed {
      logic                         valid;
      logic [VPU_SRC_PORT_ID_W-1:0] req_id;
   } sram_rd_tag_t;
endpackage

// File: rtl/vpu_rr_arbiter.sv
// Round-robin arbiter with burst lock; grant is combinational in the request cycle.
// Unserved requests are not stored: losers simply see gnt=0 until they win.
module vpu_rr_arbiter #(
   parameter int REQ_CNT = 3,
   parameter int ID_W    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REQ_CNT-1:0] req,
   input  logic [REQ_CNT-1:0] last,
   output logic [REQ_CNT-1:0] gnt,
   output logic               gnt_vld,
   output logic [ID_W-1:0]    gnt_id
);
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] lock_id;
   logic            lock_vld;
   logic [ID_W:0]   scan_idx;

   always_comb begin
      gnt      = '0;
      gnt_vld  = 1'b0;
      gnt_id   = '0;
      scan_idx = '0;
      if (lock_vld) begin
         if (req[lock_id]) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id;
         end
      end else begin
         for (int i = 0; i < REQ_CNT; i++) begin
            scan_idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(REQ_CNT))
               scan_idx = scan_idx - (ID_W+1)'(REQ_CNT);
            if (!gnt_vld && req[scan_idx[ID_W-1:0]]) begin
               gnt_vld = 1'b1;
               gnt_id  = scan_idx[ID_W-1:0];
            end
         end
      end
      gnt[gnt_id] = gnt_vld;
   end

   // The pointer is frozen for the whole burst and only moves on the releasing beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         lock_vld <= 1'b0;
         lock_id  <= '0;
      end else if (gnt_vld) begin
         if (last[gnt_id]) begin
            lock_vld <= 1'b0;
            ptr      <= (gnt_id == ID_W'(REQ_CNT-1)) ? '0 : gnt_id + ID_W'(1);
         end else begin
            lock_vld <= 1'b1;
            lock_id  <= gnt_id;
         end
      end
   end
endmodule

// File: rtl/vpu_sram_rd_arbiter.sv
// Per-bank round-robin read arbitration for the operand SRAM; ack same cycle, data 2+RD_LATENCY later.
// No request buffering: a requester holds its request until acked, a locked bank stalls others.
module vpu_sram_rd_arbiter
   import vpu_pkg::*;
#(
   parameter int REQ_CNT        = VPU_SRC_PORT_CNT,
   parameter int BANK_CNT       = SRAM_BANK_CNT,
   parameter int BANK_DEPTH_LG2 = SRAM_BANK_DEPTH_LG2,
   parameter int DATA_WIDTH     = SRAM_DATA_WIDTH,
   parameter int RD_LATENCY     = SRAM_RD_LATENCY
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [REQ_CNT-1:0]               req_i,
   input  logic [REQ_CNT*$clog2(BANK_CNT)-1:0] rid_i,
   input  logic [REQ_CNT*BANK_DEPTH_LG2-1:0] addr_i,
   input  logic [REQ_CNT-1:0]               reb_i,
   input  logic [REQ_CNT-1:0]               rlast_i,
   output logic [REQ_CNT-1:0]               ack_o,
   output logic [REQ_CNT-1:0]               rvalid_o,
   output logic [REQ_CNT*DATA_WIDTH-1:0]    rdata_o,
   output logic [BANK_CNT-1:0]              bank_ceb_o,
   output logic [BANK_CNT*BANK_DEPTH_LG2-1:0] bank_addr_o,
   input  logic [BANK_CNT*DATA_WIDTH-1:0]   bank_rdata_i
);
   localparam int BANK_LG2 = $clog2(BANK_CNT);
   localparam int ID_W     = VPU_SRC_PORT_ID_W;

   logic [REQ_CNT-1:0]        cand     [BANK_CNT];
   logic [REQ_CNT-1:0]        bank_gnt [BANK_CNT];
   logic [BANK_CNT-1:0]       gnt_vld;
   logic [ID_W-1:0]           gnt_id   [BANK_CNT];
   logic [BANK_DEPTH_LG2-1:0] gnt_addr [BANK_CNT];
   sram_rd_tag_t              ret_tail [BANK_CNT];
   logic [REQ_CNT-1:0]        ret_vld;
   logic [REQ_CNT*DATA_WIDTH-1:0] ret_dat;

   // Requests are masked during reset so ack_o reads 0 while rst is high.
   always_comb begin
      for (int b = 0; b < BANK_CNT; b++) begin
         for (int r = 0; r < REQ_CNT; r++) begin
            cand[b][r] = !rst && req_i[r] && !reb_i[r] &&
                         (rid_i[r*BANK_LG2 +: BANK_LG2] == BANK_LG2'(b));
         end
      end
   end

   always_comb begin
      ack_o = '0;
      for (int b = 0; b < BANK_CNT; b++) begin
         ack_o       = ack_o | bank_gnt[b];
         gnt_addr[b] = '0;
         for (int r = 0; r < REQ_CNT; r++) begin
            gnt_addr[b] = gnt_addr[b] |
                          ({BANK_DEPTH_LG2{bank_gnt[b][r]}} & addr_i[r*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2]);
         end
      end
   end

   for (genvar g = 0; g < BANK_CNT; g++) begin : g_bank
      sram_rd_tag_t [RD_LATENCY:0] tag_q;

      vpu_rr_arbiter #(
         .REQ_CNT (REQ_CNT),
         .ID_W    (ID_W)
      ) u_arb (
         .clk     (clk),
         .rst     (rst),
         .req     (cand[g]),
         .last    (rlast_i),
         .gnt     (bank_gnt[g]),
         .gnt_vld (gnt_vld[g]),
         .gnt_id  (gnt_id[g])
      );

      // Stage k is live in cycle T+1+k, so the tail lines up with bank_rdata_i.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            tag_q <= '0;
         else
            tag_q <= {tag_q[RD_LATENCY-1:0], sram_rd_tag_t'{valid: gnt_vld[g], req_id: gnt_id[g]}};
      end

      assign ret_tail[g] = tag_q[RD_LATENCY];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_ceb_o  <= '1;
         bank_addr_o <= '0;
      end else begin
         for (int b = 0; b < BANK_CNT; b++) begin
            bank_ceb_o[b] <= !gnt_vld[b];
            if (gnt_vld[b])
               bank_addr_o[b*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2] <= gnt_addr[b];
         end
      end
   end

   // Fixed latency means a requester sees at most one returning bank per cycle.
   always_comb begin
      ret_vld = '0;
      ret_dat = '0;
      for (int b = 0; b < BANK_CNT; b++) begin
         for (int r = 0; r < REQ_CNT; r++) begin
            if (ret_tail[b].valid && ret_tail[b].req_id == ID_W'(r)) begin
               ret_vld[r] = 1'b1;
               ret_dat[r*DATA_WIDTH +: DATA_WIDTH] = bank_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_o <= '0;
         rdata_o  <= '0;
      end else begin
         rvalid_o <= ret_vld;
         for (int r = 0; r < REQ_CNT; r++) begin
            if (ret_vld[r])
               rdata_o[r*DATA_WIDTH +: DATA_WIDTH] <= ret_dat[r*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end
endmodule

// File: tb/tb_vpu_sram_rd_arbiter.sv
// Bench for vpu_sram_rd_arbiter: vector table, directed corner sequences, and random traffic
// checked against a transaction-level model of arbitration, locking and return timing.
module tb_vpu_sram_rd_arbiter;
   localparam int N = 3, NB = 4, LG2 = 2, D = 10, DW = 256, NS = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_i, reb_i, rlast_i, ack_o, rvalid_o;
   logic [N*LG2-1:0]  rid_i;
   logic [N*D-1:0]    addr_i;
   logic [N*DW-1:0]   rdata_o;
   logic [NB-1:0]     bank_ceb_o;
   logic [NB*D-1:0]   bank_addr_o;
   logic [NB*DW-1:0]  bank_rdata_i = '0;

   int tests = 0, fails = 0, cyc = 0;

   always #5 clk = ~clk;

   vpu_sram_rd_arbiter #(
      .REQ_CNT(N), .BANK_CNT(NB), .BANK_DEPTH_LG2(D), .DATA_WIDTH(DW), .RD_LATENCY(1)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .rid_i(rid_i), .addr_i(addr_i), .reb_i(reb_i),
      .rlast_i(rlast_i), .ack_o(ack_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .bank_ceb_o(bank_ceb_o), .bank_addr_o(bank_addr_o), .bank_rdata_i(bank_rdata_i)
   );

   function automatic logic [DW-1:0] bank_word(int b, logic [D-1:0] a);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = {4'(b), 3'(i), a, 15'(a*13 + b + i)};
      return v;
   endfunction

   // SRAM macros: one cycle from strobe to data.
   always @(posedge clk)
      for (int b = 0; b < NB; b++)
         if (!bank_ceb_o[b]) bank_rdata_i[b*DW +: DW] <= bank_word(b, bank_addr_o[b*D +: D]);

   // Reference model: per-bank pointer / lock owner, plus expected outputs scheduled by cycle.
   int            ptr  [NB];
   int            lock [NB];
   bit            s_lo [NS][NB];
   logic [D-1:0]  s_addr [NS][NB];
   bit            s_rv [NS][N];
   logic [DW-1:0] s_rd [NS][N];
   logic [DW-1:0] exp_rd [N];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin ptr[b] = 0; lock[b] = -1; end
      for (int s = 0; s < NS; s++) begin
         for (int b = 0; b < NB; b++) begin s_lo[s][b] = 0; s_addr[s][b] = '0; end
         for (int r = 0; r < N; r++) begin s_rv[s][r] = 0; s_rd[s][r] = '0; end
      end
      for (int r = 0; r < N; r++) exp_rd[r] = '0;
   endtask

   task automatic step(input logic [N-1:0] req, input logic [N*LG2-1:0] rid, input logic [N*D-1:0] addr,
                       input logic [N-1:0] reb, input logic [N-1:0] rlast, output logic [N-1:0] mack);
      int slot, win, r;
      @(negedge clk);
      req_i = req; rid_i = rid; addr_i = addr; reb_i = reb; rlast_i = rlast;
      #1;
      slot = cyc % NS;
      for (int b = 0; b < NB; b++) begin
         chk("bank_ceb", DW'(bank_ceb_o[b]), DW'(!s_lo[slot][b]));
         if (s_lo[slot][b]) chk("bank_addr", DW'(bank_addr_o[b*D +: D]), DW'(s_addr[slot][b]));
         s_lo[slot][b] = 0;
      end
      for (int q = 0; q < N; q++) begin
         if (s_rv[slot][q]) exp_rd[q] = s_rd[slot][q];
         chk("rvalid", DW'(rvalid_o[q]), DW'(s_rv[slot][q]));
         chk("rdata", rdata_o[q*DW +: DW], exp_rd[q]);
         s_rv[slot][q] = 0;
      end
      mack = '0;
      for (int b = 0; b < NB; b++) begin
         win = -1;
         for (int k = 0; k < N; k++) begin
            r = (lock[b] >= 0) ? lock[b] : (ptr[b] + k) % N;
            if (win < 0 && req[r] && !reb[r] && int'(rid[r*LG2 +: LG2]) == b) win = r;
         end
         if (win >= 0) begin
            mack[win] = 1'b1;
            s_lo[(cyc+1)%NS][b]   = 1;
            s_addr[(cyc+1)%NS][b] = addr[win*D +: D];
            s_rv[(cyc+3)%NS][win] = 1;
            s_rd[(cyc+3)%NS][win] = bank_word(b, addr[win*D +: D]);
            if (rlast[win]) begin lock[b] = -1; ptr[b] = (win + 1) % N; end
            else lock[b] = win;
         end
      end
      chk("ack", DW'(ack_o), DW'(mack));
      cyc++;
   endtask

   task automatic idle(input int n);
      logic [N-1:0] m;
      for (int i = 0; i < n; i++) step('0, '0, '0, '0, '1, m);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"},    DW'(ack_o), '0);
      chk({tag, "_rvalid"}, DW'(rvalid_o), '0);
      chk({tag, "_rdata"},  DW'(rdata_o), '0);
      chk({tag, "_ceb"},    DW'(bank_ceb_o), DW'(4'hF));
      chk({tag, "_baddr"},  DW'(bank_addr_o), '0);
   endtask

   typedef struct {
      logic [N-1:0]     req;
      logic [N*LG2-1:0] rid;
      logic [N-1:0]     reb;
      logic [N-1:0]     rlast;
      logic [N-1:0]     ack;
   } vec_t;

   vec_t vt [16];

   // Random traffic state: one pending request per requester, bursts stay on one bank.
   bit           pend [N], inb [N], p_last [N];
   int           beats [N];
   logic [1:0]   p_rid [N];
   logic [D-1:0] p_addr [N];

   initial begin
      logic [N-1:0]     mack, rq, rb, rl;
      logic [N*LG2-1:0] ri;
      logic [N*D-1:0]   ad;

      //               req     rid {r2,r1,r0}       reb     rlast   ack
      vt[0]  = '{3'b111, {2'd0, 2'd0, 2'd0}, 3'b000, 3'b111, 3'b001};
      vt[1]  = '{3'b111, {2'd0, 2'd0, 2'd0}, 3'b000, 3'b111, 3'b010};
      vt[2]  = '{3'b111, {2'd0, 2'd0, 2'd0}, 3'b000, 3'b111, 3'b100};
      vt[3]  = '{3'b111, {2'd0, 2'd0, 2'd0}, 3'b000, 3'b111, 3'b001};
      vt[4]  = '{3'b111, {2'd3, 2'd1, 2'd0}, 3'b000, 3'b111, 3'b111};
      vt[5]  = '{3'b001, {2'd0, 2'd0, 2'd2}, 3'b001, 3'b111, 3'b000};
      vt[6]  = '{3'b110, {2'd2, 2'd2, 2'd0}, 3'b010, 3'b111, 3'b100};
      vt[7]  = '{3'b011, {2'd0, 2'd2, 2'd2}, 3'b000, 3'b111, 3'b001};
      vt[8]  = '{3'b010, {2'd0, 2'd1, 2'd0}, 3'b000, 3'b101, 3'b010};
      vt[9]  = '{3'b011, {2'd0, 2'd1, 2'd1}, 3'b000, 3'b101, 3'b010};
      vt[10] = '{3'b011, {2'd0, 2'd1, 2'd1}, 3'b000, 3'b111, 3'b010};
      vt[11] = '{3'b001, {2'd0, 2'd1, 2'd1}, 3'b000, 3'b111, 3'b001};
      vt[12] = '{3'b100, {2'd3, 2'd0, 2'd0}, 3'b000, 3'b011, 3'b100};
      vt[13] = '{3'b101, {2'd3, 2'd0, 2'd3}, 3'b100, 3'b011, 3'b000};
      vt[14] = '{3'b101, {2'd3, 2'd0, 2'd3}, 3'b000, 3'b111, 3'b100};
      vt[15] = '{3'b001, {2'd3, 2'd0, 2'd3}, 3'b000, 3'b111, 3'b001};

      rst = 1'b1; req_i = '0; rid_i = '0; addr_i = '0; reb_i = '0; rlast_i = '1;
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      rst = 1'b0;

      // Single read: r0 -> bank 2, row 0x1A.
      step(3'b001, {2'd0, 2'd0, 2'd2}, {20'd0, 10'h1A}, 3'b000, 3'b111, mack);
      chk("single_ack", DW'(ack_o), DW'(3'b001));
      idle(1);
      chk("single_ceb", DW'(bank_ceb_o), DW'(4'b1011));
      chk("single_addr", DW'(bank_addr_o[2*D +: D]), DW'(10'h1A));
      idle(2);
      chk("single_rvalid", DW'(rvalid_o), DW'(3'b001));
      chk("single_rdata", rdata_o[0 +: DW], bank_word(2, 10'h1A));
      idle(2);

      for (int i = 0; i < 16; i++) begin
         step(vt[i].req, vt[i].rid, {10'(300 + i), 10'(200 + i), 10'(100 + i)},
              vt[i].reb, vt[i].rlast, mack);
         chk("vec_ack", DW'(ack_o), DW'(vt[i].ack));
      end
      idle(4);

      for (int r = 0; r < N; r++) begin pend[r] = 0; inb[r] = 0; beats[r] = 0; end
      for (int c = 0; c < 600; c++) begin
         rq = '0; rb = '0; rl = '0; ri = '0; ad = '0;
         for (int r = 0; r < N; r++) begin
            if (!pend[r] && $urandom_range(9) < 6) begin
               pend[r]   = 1;
               p_rid[r]  = inb[r] ? p_rid[r] : ($urandom_range(1) ? 2'd0 : 2'($urandom_range(3)));
               p_addr[r] = D'($urandom);
               p_last[r] = (inb[r] && beats[r] >= 3) ? 1'b1 : ($urandom_range(3) != 0);
            end
            rq[r] = pend[r];
            rb[r] = pend[r] && ($urandom_range(4) == 0);
            rl[r] = p_last[r];
            ri[r*LG2 +: LG2] = p_rid[r];
            ad[r*D +: D]     = p_addr[r];
         end
         step(rq, ri, ad, rb, rl, mack);
         for (int r = 0; r < N; r++) begin
            if (mack[r]) begin
               pend[r] = 0;
               if (p_last[r]) begin inb[r] = 0; beats[r] = 0; end
               else begin inb[r] = 1; beats[r]++; end
            end
         end
      end
      // Close any open bursts so bank 0 is free for the reset sequence.
      for (int r = 0; r < N; r++) begin
         if (inb[r]) begin
            ri = '0; ri[r*LG2 +: LG2] = p_rid[r];
            rq = '0; rq[r] = 1'b1;
            step(rq, ri, '0, '0, '1, mack);
            chk("burst_close", DW'(mack[r]), DW'(1'b1));
         end
      end
      idle(4);

      // Reset between ack and return; pointer must restart at 0.
      step(3'b001, '0, {20'd0, 10'h2B}, 3'b000, 3'b111, mack);
      chk("pre_rst_ack", DW'(ack_o), DW'(3'b001));
      idle(1);
      req_i = 3'b111; rid_i = '0; reb_i = '0; rlast_i = '1;
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("mid");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      req_i = '0;
      rst = 1'b0;
      idle(4);
      step(3'b111, '0, {10'd7, 10'd6, 10'd5}, 3'b000, 3'b111, mack);
      chk("post_rst_ptr", DW'(ack_o), DW'(3'b001));
      idle(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
